veri_phase_comp_accum: RTL and testbench

//  Registered, parametrised saturating phase accumulator (digital loop filter) for bang-bang phase comparators.

---
 rtl/veri_phase_comp_accum_if.sv | 22 ++
 rtl/veri_phase_comp_accum.sv | 63 ++++++
 tb/tb_veri_phase_comp_accum.sv | 138 +++++++++++++
 3 files changed

// File: rtl/veri_phase_comp_accum_if.sv
// veri_phase_comp_accum_if: phase-detector samples, control and code/status bundle
interface veri_phase_comp_accum_if #(parameter int WIDTH = 2);
  logic             pd_valid;
  logic             pd_down;
  logic             hold;
  logic             load;
  logic [WIDTH-1:0] load_code;
  logic [WIDTH-1:0] code_out;
  logic             code_valid;
  logic             step_up;
  logic             step_dn;
  logic             sat_hi;
  logic             sat_lo;
  modport master (
    output pd_valid, pd_down, hold, load, load_code,
    input  code_out, code_valid, step_up, step_dn, sat_hi, sat_lo
  );
  modport slave (
    input  pd_valid, pd_down, hold, load, load_code,
    output code_out, code_valid, step_up, step_dn, sat_hi, sat_lo
  );
endinterface

// File: rtl/veri_phase_comp_accum.sv
// veri_phase_comp_accum: majority-vote saturating phase accumulator for bang-bang phase detectors
module veri_phase_comp_accum #(
  parameter int WIDTH      = 2,
  parameter int MIN_CODE   = 0,
  parameter int MAX_CODE   = 2,
  parameter int RESET_CODE = 0,
  parameter int VOTE_LEN   = 1
) (
  input logic clk,
  input logic rst_n,
  veri_phase_comp_accum_if.slave bus
);
  localparam int CW = $clog2(VOTE_LEN + 1);
  localparam int SW = CW + 1;
  localparam logic [WIDTH-1:0] MINC = WIDTH'(MIN_CODE);
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_CODE);
  localparam logic [WIDTH-1:0] RSTC = WIDTH'(RESET_CODE);
  localparam logic [CW-1:0]    LEN  = CW'(VOTE_LEN);
  logic [WIDTH-1:0] code_q, code_d, clamp;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_n;
  logic [SW-1:0]    sum_q, sum_d, sum_n;
  logic valid_q, valid_d, up_q, up_d, dn_q, dn_d;
  logic sample, decide, vote_up, vote_dn;
  always_comb begin
    sample  = bus.pd_valid & ~bus.hold & ~bus.load;
    cnt_n   = cnt_q + CW'(1);
    sum_n   = bus.pd_down ? sum_q - SW'(1) : sum_q + SW'(1);
    decide  = sample && cnt_n == LEN;
    vote_up = decide && !sum_n[SW-1] && sum_n != '0;
    vote_dn = decide && sum_n[SW-1];
    clamp   = int'(bus.load_code) > MAX_CODE ? MAXC :
              int'(bus.load_code) < MIN_CODE ? MINC : bus.load_code;
    up_d    = vote_up && code_q < MAXC;
    dn_d    = vote_dn && code_q > MINC;
    code_d  = bus.load ? clamp : up_d ? code_q + WIDTH'(1) : dn_d ? code_q - WIDTH'(1) : code_q;
    cnt_d   = (bus.load || decide) ? '0 : sample ? cnt_n : cnt_q;
    sum_d   = (bus.load || decide) ? '0 : sample ? sum_n : sum_q;
    valid_d = bus.load | decide;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= RSTC;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end
  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.step_up    = up_q;
  assign bus.step_dn    = dn_q;
  assign bus.sat_hi     = code_q == MAXC;
  assign bus.sat_lo     = code_q == MINC;
endmodule

// File: tb/tb_veri_phase_comp_accum.sv
// tb_veri_phase_comp_accum: three configurations driven in lockstep and checked against a vote-count model
module tb_veri_phase_comp_accum;
  localparam int MINC = 0;
  localparam int MAXC = 2;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic pd_valid = 1'b0, pd_down = 1'b0, hold = 1'b0, load = 1'b0;
  logic [1:0] load_code = 2'd0;
  logic [6:0] o[3];
  int n_chk = 0, n_fail = 0;
  int m_code[3], m_cnt[3], m_sum[3];
  bit m_v[3], m_u[3], m_d[3];
  always #5 clk = ~clk;
  // g=0: defaults; g=1: VOTE_LEN=4; g=2: VOTE_LEN=4, RESET_CODE=1
  for (genvar g = 0; g < 3; g++) begin : gd
    veri_phase_comp_accum_if #(.WIDTH(2)) bus ();
    veri_phase_comp_accum #(.VOTE_LEN(g == 0 ? 1 : 4), .RESET_CODE(g == 2 ? 1 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.pd_valid  = pd_valid;
    assign bus.pd_down   = pd_down;
    assign bus.hold      = hold;
    assign bus.load      = load;
    assign bus.load_code = load_code;
    assign o[g] = {bus.code_out, bus.code_valid, bus.step_up, bus.step_dn, bus.sat_hi, bus.sat_lo};
  end
  function automatic int vl(int k);
    return k == 0 ? 1 : 4;
  endfunction
  function automatic int pack(int code, int v, int u, int d);
    return code * 32 + v * 16 + u * 8 + d * 4 + (code == MAXC ? 2 : 0) + (code == MINC ? 1 : 0);
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got {code,valid,up,dn,hi,lo}=%b required %b", nm, 7'(act), 7'(exp));
    end
  endtask
  task automatic lit(string nm, int k, int code, int v, int u, int d);
    chk(nm, int'(o[k]), pack(code, v, u, d));
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_code[k] = k == 2 ? 1 : 0;
      m_cnt[k] = 0;
      m_sum[k] = 0;
      {m_v[k], m_u[k], m_d[k]} = 3'b000;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      {m_v[k], m_u[k], m_d[k]} = 3'b000;
      if (load) begin
        m_code[k] = int'(load_code) > MAXC ? MAXC : int'(load_code) < MINC ? MINC : int'(load_code);
        m_cnt[k] = 0;
        m_sum[k] = 0;
        m_v[k] = 1'b1;
      end else if (!hold && pd_valid) begin
        m_sum[k] += pd_down ? -1 : 1;
        m_cnt[k]++;
        if (m_cnt[k] == vl(k)) begin
          m_v[k] = 1'b1;
          if (m_sum[k] > 0 && m_code[k] < MAXC) begin
            m_code[k]++;
            m_u[k] = 1'b1;
          end else if (m_sum[k] < 0 && m_code[k] > MINC) begin
            m_code[k]--;
            m_d[k] = 1'b1;
          end
          m_cnt[k] = 0;
          m_sum[k] = 0;
        end
      end
    end
  endtask
  always @(negedge clk)
    if (run && rst_n)
      for (int k = 0; k < 3; k++)
        chk($sformatf("cycle_dut%0d", k), int'(o[k]), pack(m_code[k], int'(m_v[k]), int'(m_u[k]), int'(m_d[k])));
  task automatic cyc(logic v, logic d, logic h, logic l, logic [1:0] lc);
    pd_valid = v;
    pd_down = d;
    hold = h;
    load = l;
    load_code = lc;
    model_step();
    @(negedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    #1;
    lit("rst_dut0", 0, 0, 0, 0, 0);
    lit("rst_dut1", 1, 0, 0, 0, 0);
    lit("rst_dut2", 2, 1, 0, 0, 0);
    rst_n = 1'b1;
    run = 1'b1;
    cyc(1, 0, 0, 0, 0); lit("s1_up1", 0, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0); lit("s1_up2", 0, 2, 1, 1, 0);
    cyc(1, 0, 0, 0, 0); lit("s1_sat", 0, 2, 1, 0, 0);
    cyc(0, 0, 0, 1, 0); lit("s2_load0", 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0); lit("s2_satlo", 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 3); lit("s3_clamp", 0, 2, 1, 0, 0);
    cyc(1, 1, 0, 0, 0); lit("s3_down", 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    lit("s4_pending", 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); lit("s4_vote_up", 1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    lit("s4_pending2", 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0); lit("s4_tie", 1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
    lit("s5_hold", 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); lit("s5_third", 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); lit("s5_vote_up", 1, 2, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    lit("s6_pre", 2, 0, 0, 0, 0);
    {pd_valid, pd_down, hold, load} = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    lit("s6_async_rst2", 2, 1, 0, 0, 0);
    lit("s6_async_rst0", 0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    lit("s6_no_early", 2, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); lit("s6_one_step", 2, 2, 1, 1, 0);
    cyc(0, 0, 0, 0, 0); lit("s6_idle", 2, 2, 0, 0, 0);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
